// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder.
// Pure declarations: no logic, no latency, no flow control.
package nibbleadd_pkg;

  localparam int   NIB_W    = 4;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for the nibble-serial adder: start/busy/done handshake.
// Requester drives start/ctrl/A/B; the adder returns busy/done/q (q holds until next done).
interface nibble_serial_adder_if #(
  parameter int N_NIB = 2
);
  localparam int W = 4 * N_NIB;

  logic         start;
  logic         ctrl;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W:0]   q;

  modport master (
    output start, ctrl, A, B,
    input  busy, done, q
  );

  modport slave (
    input  start, ctrl, A, B,
    output busy, done, q
  );

endinterface

// File: rtl/nibble_serial_adder_add4.sv
// Combinational 4-bit adder with carry in/out; zero latency, no flow control.
module nibble_add4
  import nibbleadd_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
  assign sum   = total[NIB_W-1:0];
  assign cout  = total[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial A+/-B, LSB nibble first; done/q appear N_NIB+1 cycles after accepted start.
// start ignored while busy; back-to-back start accepted in DONE. NIBADD_SAT_EN selects clamping.
module nibble_serial_adder
  import nibbleadd_pkg::*;
#(
  parameter int N_NIB = 2
)
(
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);

  localparam int                W     = NIB_W * N_NIB;
  localparam int                IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_NIB - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       result_q, result_d;
  logic [W:0]         q_q, q_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ctrl_q, ctrl_d;
  logic               carry_q, carry_d;
  logic               done_q, done_d;

  logic [NIB_W-1:0]   a_nib, b_nib, sum_nib;
  logic               cout;
  logic               accept;
  logic               out_msb;
  logic [W:0]         q_final;

  // Current nibble pair; B is inverted for subtract so carry-in=1 completes two's complement.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < N_NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W] ^ {NIB_W{ctrl_q}};
      end
    end
  end

  nibble_add4 u_add4 (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (cout)
  );

  // For subtract the final carry is the inverse of the unsigned borrow.
  always_comb begin
    out_msb = (ctrl_q == MODE_SUB) ? ~carry_q : carry_q;
`ifdef NIBADD_SAT_EN
    if (out_msb) begin
      q_final = (ctrl_q == MODE_SUB) ? '0 : {1'b0, {W{1'b1}}};
    end else begin
      q_final = {1'b0, result_q};
    end
`else
    q_final = {out_msb, result_q};
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    q_d      = q_q;
    idx_d    = idx_q;
    ctrl_d   = ctrl_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    accept   = 1'b0;

    case (state_q)
      IDLE: begin
        accept = bus.start;
      end
      RUN: begin
        for (int i = 0; i < N_NIB; i++) begin
          if (idx_q == IDX_W'(i)) begin
            result_d[i*NIB_W +: NIB_W] = sum_nib;
          end
        end
        carry_d = cout;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        q_d     = q_final;
        done_d  = 1'b1;
        state_d = IDLE;
        accept  = bus.start;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      a_d     = bus.A;
      b_d     = bus.B;
      ctrl_d  = bus.ctrl;
      carry_d = bus.ctrl;
      idx_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      q_q      <= '0;
      idx_q    <= '0;
      ctrl_q   <= MODE_ADD;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      q_q      <= q_d;
      idx_q    <= idx_d;
      ctrl_q   <= ctrl_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.q    = q_q;

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Parametrised, sequential successor to the combinational nibble adder.
- Adds or subtracts two N_NIB-nibble operands one nibble per clock, LSB nibble first, through a single 4-bit adder and a carry register.
- Uses a start/busy/done handshake and holds the result registered until the next operation.
- Sits between operand registers and result consumers in the datapath labs; sized for 8-bit operands by default.

Parameters:
- N_NIB, 2, number of 4-bit nibbles per operand (legal 1..8); operand width W = 4*N_NIB.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a rising edge when busy=0.
- ctrl  input  1  mode, latched with start: 0 = A+B, 1 = A-B.
- A  input  W  operand A, latched with start.
- B  input  W  operand B, latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when q is updated.
- q  output  W+1  result: {carry, sum} for add; {borrow, difference} for subtract.

Behaviour:
- Reset is one clock, synchronous and active-high; the port names are clk and rst.
- Reset values: busy=0, done=0, q=0, state=IDLE, carry=0, nibble index=0.
- States and transitions:
  - IDLE: start=1 latches A, B and ctrl; sets idx=0 and carry=ctrl; goes to RUN. start=0 stays in IDLE.
  - RUN: each cycle computes s = A[idx] + (B[idx] XOR {4{ctrl}}) + carry.
    - Writes s[3:0] into result nibble idx; carry <= s[4]; idx <= idx+1.
    - When idx = N_NIB-1, goes to DONE.
  - DONE: q <= {ctrl ? ~carry : carry, result}; done=1 for exactly this cycle.
    - Next state is IDLE, or RUN if start=1 (back-to-back accepted).
- busy=1 in RUN only; busy=0 in IDLE and DONE.
- start while busy=1 is ignored; latched operands and mode are unaffected.
- Latency: start sampled at edge k gives done=1 and the new q after edge k+N_NIB+1.
- Throughput: one operation per N_NIB+1 cycles.
- q holds its value from the done cycle until the next DONE or reset; operand inputs may change freely after the accepting edge.
- Width rules:
  - Add: q = A+B, modulo 2^(W+1) never wraps.
  - Subtract: q[W-1:0] = (A-B) mod 2^W; q[W] = 1 iff A<B (unsigned borrow).
- Boundary cases:
  - A=B=all-ones with add gives q = 2^(W+1)-2.
  - A=B with subtract gives q=0.
  - A=0, B=0 gives q=0 in both modes.
- rst=1 mid-operation aborts immediately: no done pulse, q returns to 0.
- rst has priority over start on the same edge.

Optional Feature:
- NIBADD_SAT_EN defined:
  - Subtract with borrow clamps q to 0.
  - Add with carry-out clamps q to {1'b0, all-ones}, so q[W] is always 0.
  - Latency is unchanged.
- NIBADD_SAT_EN undefined: wrap/borrow behaviour exactly as above.

Decomposition:
- Package nibbleadd_pkg holds:
  - constant NIB_W=4;
  - mode constants MODE_ADD=0 and MODE_SUB=1;
  - state enum {IDLE, RUN, DONE}.
- Sub-module nibble_add4: combinational 4-bit adder with cin/cout, instantiated once.
- The top level owns the FSM, index counter, carry register and result register.

Test Plan:
- N_NIB=2, ctrl=0, A=0xFF, B=0x80, start pulse → busy high 2 cycles; done 3 cycles after start; q=0x17F.
- ctrl=1, A=0xD5, B=0xAA → q=0x02B; then A=0x00, B=0xAA → q=0x156 (SAT_EN: q=0x000); ctrl=1, A=B=0x59 → q=0x000.
- Second start asserted while busy, with different A/B → ignored, first result returned; start held high through DONE → next operation begins immediately, done every 3 cycles.
- rst asserted 1 cycle after start, A=0xFF, B=0xFF → no done pulse, busy=0, q=0; the following operation A=0x62, B=0x00 add → q=0x062.
- N_NIB=4, add A=0xFFFF, B=0xFFFF → q=0x1FFFE after 5 cycles; subtract A=0x1000, B=0x0001 → q=0x00FFF.
- Random A/B/ctrl with N_NIB=1, 2 and 8 → q matches reference model (A±B with borrow/carry); done pulse is exactly 1 cycle wide.
